// File: rtl/spc7110_alu_seq.sv
// spc7110_alu_seq: iterative multiply/divide sequencer for the SPC7110 ALU.
// One shared datapath runs a 16-step shift-add multiply or a 32-step restoring
// divide, with signed-mode magnitude conversion before the run and sign
// restoration after it.
// Optional macro SPC7110_ALU_ACCURATE_TIMING_EN adds a HOLD state and an 8-bit
// latency counter so busy/done track MUL_CYCLES / DIV_CYCLES.
module spc7110_alu_seq #(
  parameter int unsigned MUL_CYCLES = 30,
  parameter int unsigned DIV_CYCLES = 40
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start_mul,
  input  logic        start_div,
  input  logic        signed_mode,
  input  logic [31:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [15:0] remainder
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREP    = 3'd1;
  localparam logic [2:0] S_MUL_RUN = 3'd2;
  localparam logic [2:0] S_DIV_RUN = 3'd3;
  localparam logic [2:0] S_FIXUP   = 3'd4;
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
  localparam logic [2:0] S_HOLD    = 3'd5;

  // Requested latencies clamped to [compute latency, 255].
  localparam int unsigned MUL_LAT_I = (MUL_CYCLES < 18) ? 18 : ((MUL_CYCLES > 255) ? 255 : MUL_CYCLES);
  localparam int unsigned DIV_LAT_I = (DIV_CYCLES < 34) ? 34 : ((DIV_CYCLES > 255) ? 255 : DIV_CYCLES);
  localparam logic [8:0]  MUL_LAT   = 9'(MUL_LAT_I);
  localparam logic [8:0]  DIV_LAT   = 9'(DIV_LAT_I);
`endif

  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d;          // multiplicand (shifts left) / dividend then quotient
  logic [15:0] b_q, b_d;          // multiplier (shifts right) / divisor
  logic [31:0] acc_q, acc_d;      // product accumulator
  logic [16:0] rem_q, rem_d;      // partial remainder
  logic [4:0]  iter_q, iter_d;
  logic [15:0] orig_lo_q, orig_lo_d;
  logic        is_div_q, is_div_d;
  logic        sgn_q, sgn_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;
  logic [31:0] res_q, res_d;
  logic [15:0] rem_out_q, rem_out_d;
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
  logic [7:0]  lat_q, lat_d;
  logic [8:0]  lat_tgt;
  logic        lat_met;
`endif

  logic [31:0] fix_res;
  logic [15:0] fix_rem;
  logic [16:0] div_shift;

  // Next-state, datapath step and completion logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    iter_d    = iter_q;
    orig_lo_d = orig_lo_q;
    is_div_d  = is_div_q;
    sgn_d     = sgn_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    res_d     = res_q;
    rem_out_d = rem_out_q;
    fix_res   = '0;
    fix_rem   = '0;
    div_shift = {rem_q[15:0], a_q[31]};
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
    lat_d   = lat_q;
    lat_tgt = is_div_q ? DIV_LAT : MUL_LAT;
    lat_met = (({1'b0, lat_q} + 9'd1) >= lat_tgt);
`endif

    // Sign-restored result, valid while in FIXUP.
    if (!is_div_q) begin
      fix_res = (sgn_q && (neg_a_q ^ neg_b_q)) ? (~acc_q + 32'd1) : acc_q;
      fix_rem = '0;
    end else if (dz_q) begin
      fix_res = '0;
      fix_rem = orig_lo_q;
    end else begin
      fix_res = (sgn_q && (neg_a_q ^ neg_b_q)) ? (~a_q + 32'd1) : a_q;
      fix_rem = (sgn_q && neg_a_q) ? (~rem_q[15:0] + 16'd1) : rem_q[15:0];
    end

    if (start_mul || start_div) begin
      // A start in any state (re)launches; an in-flight op is dropped silently.
      state_d   = S_PREP;
      a_d       = op_a;
      b_d       = op_b;
      orig_lo_d = op_a[15:0];
      is_div_d  = start_div;
      sgn_d     = signed_mode;
      iter_d    = '0;
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
      lat_d     = '0;
`endif
    end else begin
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
      if (state_q != S_IDLE && lat_q != 8'hFF) lat_d = lat_q + 8'd1;
`endif
      case (state_q)
        S_PREP: begin
          acc_d   = '0;
          rem_d   = '0;
          iter_d  = '0;
          dz_d    = 1'b0;
          neg_a_d = 1'b0;
          neg_b_d = 1'b0;
          if (sgn_q && b_q[15]) begin
            neg_b_d = 1'b1;
            b_d     = ~b_q + 16'd1;
          end
          if (is_div_q) begin
            if (sgn_q && a_q[31]) begin
              neg_a_d = 1'b1;
              a_d     = ~a_q + 32'd1;
            end
            if (b_q == '0) begin
              dz_d    = 1'b1;
              state_d = S_FIXUP;
            end else begin
              state_d = S_DIV_RUN;
            end
          end else begin
            neg_a_d = sgn_q & a_q[15];
            a_d     = {16'h0000, (sgn_q && a_q[15]) ? (~a_q[15:0] + 16'd1) : a_q[15:0]};
            state_d = S_MUL_RUN;
          end
        end
        S_MUL_RUN: begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d    = {a_q[30:0], 1'b0};
          b_d    = {1'b0, b_q[15:1]};
          iter_d = iter_q + 5'd1;
          if (iter_q == 5'd15) state_d = S_FIXUP;
        end
        S_DIV_RUN: begin
          if (div_shift >= {1'b0, b_q}) begin
            rem_d = div_shift - {1'b0, b_q};
            a_d   = {a_q[30:0], 1'b1};
          end else begin
            rem_d = div_shift;
            a_d   = {a_q[30:0], 1'b0};
          end
          iter_d = iter_q + 5'd1;
          if (iter_q == 5'd31) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          // Divide-by-zero lingers one extra FIXUP cycle so it completes at cycle 3.
          if (dz_q && iter_q == 5'd0) begin
            iter_d = 5'd1;
          end else begin
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
            if (lat_met) begin
              res_d     = fix_res;
              rem_out_d = fix_rem;
              done_d    = 1'b1;
              state_d   = S_IDLE;
            end else begin
              acc_d   = fix_res;
              rem_d   = {1'b0, fix_rem};
              state_d = S_HOLD;
            end
`else
            res_d     = fix_res;
            rem_out_d = fix_rem;
            done_d    = 1'b1;
            state_d   = S_IDLE;
`endif
          end
        end
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
        S_HOLD: begin
          if (lat_met) begin
            res_d     = acc_q;
            rem_out_d = rem_q[15:0];
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      iter_q    <= '0;
      orig_lo_q <= '0;
      is_div_q  <= 1'b0;
      sgn_q     <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
      rem_out_q <= '0;
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
      lat_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      iter_q    <= iter_d;
      orig_lo_q <= orig_lo_d;
      is_div_q  <= is_div_d;
      sgn_q     <= sgn_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      res_q     <= res_d;
      rem_out_q <= rem_out_d;
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
      lat_q     <= lat_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result    = res_q;
  assign remainder = rem_out_q;

endmodule

// File: tb/tb_spc7110_alu_seq.sv
// Directed bench for spc7110_alu_seq: vector table plus abort, simultaneous
// start and mid-operation reset sequences.
module tb_spc7110_alu_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start_mul;
  logic        start_div;
  logic        signed_mode;
  logic [31:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [15:0] remainder;

  spc7110_alu_seq dut (
    .CLK(CLK), .RESET(RESET), .start_mul(start_mul), .start_div(start_div),
    .signed_mode(signed_mode), .op_a(op_a), .op_b(op_b), .busy(busy),
    .done(done), .result(result), .remainder(remainder)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit          div;
    bit          sgn;
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] exp_res;
    logic [15:0] exp_rem;
    int          cyc;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(input bit div, input int compute);
`ifdef SPC7110_ALU_ACCURATE_TIMING_EN
    int tgt;
    tgt = div ? 40 : 30;
    return (compute > tgt) ? compute : tgt;
`else
    return compute;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge (cycle 0).
  task automatic launch(input bit mul, input bit div, input bit sgn, input logic [31:0] a, input logic [15:0] b);
    start_mul   = mul;
    start_div   = div;
    signed_mode = sgn;
    op_a        = a;
    op_b        = b;
    @(posedge CLK);
    @(negedge CLK);
    start_mul = 1'b0;
    start_div = 1'b0;
    op_a      = 32'h5A5A_5A5A;
    op_b      = 16'hA5A5;
  endtask

  // Waits for done from cycle cyc0; checks latency, busy continuity and pulse width.
  task automatic wait_done(input string name, input int cyc0, input int exp_cyc);
    int  cyc;
    bit  busy_ok;
    cyc     = cyc0;
    busy_ok = 1'b1;
    while (!done && cyc < 400) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      if (!done && busy !== 1'b1) busy_ok = 1'b0;
    end
    check({name, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; start_mul = 1'b0; start_div = 1'b0; signed_mode = 1'b0;
    op_a = '0; op_b = '0;
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_1234, 16'h5678, 32'h0626_0060, 16'h0000, 18};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_FFFF, 16'h0002, 32'hFFFF_FFFE, 16'h0000, 18};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_8000, 16'h8000, 32'h4000_0000, 16'h0000, 18};
    vecs[3]  = '{1'b1, 1'b0, 32'h0001_2345, 16'h0010, 32'h0000_1234, 16'h0005, 34};
    vecs[4]  = '{1'b1, 1'b1, 32'hFFFF_FF9C, 16'h0007, 32'hFFFF_FFF2, 16'hFFFE, 34};
    vecs[5]  = '{1'b1, 1'b0, 32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, 16'hBEEF, 3};
    vecs[6]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, 16'hBEEF, 3};
    vecs[7]  = '{1'b1, 1'b1, 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'h0000, 34};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_FFFF, 16'hFFFF, 32'hFFFE_0001, 16'h0000, 18};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 34};
    vecs[10] = '{1'b0, 1'b0, 32'hABCD_0003, 16'h0005, 32'h0000_000F, 16'h0000, 18};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0007, 16'hFFFE, 32'hFFFF_FFFD, 16'h0001, 34};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_remainder", {16'd0, remainder}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      launch(!vecs[i].div, vecs[i].div, vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), 0, lat(vecs[i].div, vecs[i].cyc));
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("vec%0d_remainder", i), {16'd0, remainder}, {16'd0, vecs[i].exp_rem});
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_result_hold", i), result, vecs[i].exp_res);
    end

    // Multiply aborted by a divide sampled at cycle 5.
    begin
      int ndone;
      ndone = 0;
      launch(1'b1, 1'b0, 1'b0, 32'h0000_1234, 16'h5678);
      for (int c = 1; c < 5; c++) begin
        @(posedge CLK);
        @(negedge CLK);
        if (done) ndone++;
      end
      launch(1'b0, 1'b1, 1'b0, 32'h0001_2345, 16'h0010);
      if (done) ndone++;
      check("abort_no_early_done", 32'(ndone), 32'd0);
      wait_done("abort", 5, 5 + lat(1'b1, 34));
      check("abort_result", result, 32'h0000_1234);
      check("abort_remainder", {16'd0, remainder}, 32'h0000_0005);
    end

    // Simultaneous starts: divide wins.
    launch(1'b1, 1'b1, 1'b0, 32'h0001_2345, 16'h0010);
    wait_done("both", 0, lat(1'b1, 34));
    check("both_result", result, 32'h0000_1234);
    check("both_remainder", {16'd0, remainder}, 32'h0000_0005);

    // Reset at cycle 10 of a divide.
    begin
      int ndone;
      ndone = 0;
      launch(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 16'h0003);
      for (int c = 1; c < 10; c++) begin
        @(posedge CLK);
        @(negedge CLK);
      end
      RESET = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_remainder", {16'd0, remainder}, 32'd0);
      for (int c = 0; c < 60; c++) begin
        @(posedge CLK);
        @(negedge CLK);
        if (done) ndone++;
      end
      check("rst_no_done", 32'(ndone), 32'd0);
      launch(1'b1, 1'b0, 1'b0, 32'h0000_1234, 16'h5678);
      wait_done("post_rst", 0, lat(1'b0, 18));
      check("post_rst_result", result, 32'h0626_0060);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
